// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter
//   Two-port round-robin arbiter in front of a single-word SDRAM controller.
//   Port 0 is the CPU, port 1 the DMA/video engine. A winning request is
//   latched in IDLE, issued to the controller, and answered with a one-cycle
//   ack (plus error if the controller never accepted the request in time).
//
// Ports
//   clock, reset            clock and asynchronous active-high reset
//   req/write/address/wdata per-port request fields (port n in slice n)
//   rdata, ack, error       completion signals, valid in the ack cycle only
//   busy                    high whenever the arbiter is not idle
//   sd_*                    SDRAM controller command/data/status interface
module sdram_access_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              write,
  input  logic [2*ADDR_WIDTH-1:0] address,
  input  logic [31:0]             wdata,
  output logic [15:0]             rdata,
  output logic [1:0]              ack,
  output logic [1:0]              error,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   sd_address,
  output logic [9:0]              sd_access_num,
  output logic [15:0]             sd_data_in,
  input  logic [15:0]             sd_data_out,
  output logic                    sd_write_request,
  output logic                    sd_read_request,
  input  logic                    sd_write_flag,
  input  logic                    sd_read_flag,
  input  logic                    sd_idle
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_XFER, S_DRAIN, S_DONE} state_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  // Per-port views of the packed request buses.
  logic [ADDR_WIDTH-1:0] port_addr  [2];
  logic [15:0]           port_wdata [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign port_addr[gi]  = address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign port_wdata[gi] = wdata[gi*16 +: 16];
    end
  endgenerate

  state_t                state_q, state_d;
  logic                  port_q, port_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [9:0]            count_q, count_d;
  logic                  err_q, err_d;
  logic [15:0]           rd_q, rd_d;
  logic                  last_q, last_d;

  logic [15:0]           rdata_q, rdata_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            error_q, error_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] sd_address_q, sd_address_d;
  logic [9:0]            sd_access_num_q, sd_access_num_d;
  logic [15:0]           sd_data_in_q, sd_data_in_d;
  logic                  sd_write_request_q, sd_write_request_d;
  logic                  sd_read_request_q, sd_read_request_d;

  logic grant;
  logic flag_match;

  // Controller status flag that belongs to the latched direction.
  assign flag_match = write_q ? sd_write_flag : sd_read_flag;

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    rd_d    = rd_q;
    last_d  = last_q;
    // Both requesting: the port not served last wins; otherwise the lone requester.
    grant   = (req == 2'b11) ? ~last_q : req[1];

    case (state_q)
      S_IDLE: begin
        if ((req != 2'b00) && sd_idle) begin
          port_d  = grant;
          write_d = write[grant];
          addr_d  = port_addr[grant];
          wdata_d = port_wdata[grant];
          count_d = '0;
          err_d   = 1'b0;
          rd_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        count_d = count_q + 10'd1;
        if (flag_match) begin
          state_d = S_XFER;
        end else if (count_d == TIMEOUT_CNT) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_XFER: begin
        if (sd_read_flag) begin
          rd_d = sd_data_out;
        end
        if (!flag_match) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sd_idle) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = port_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    rdata_d            = '0;
    ack_d              = '0;
    error_d            = '0;
    busy_d             = (state_d != S_IDLE);
    sd_address_d       = '0;
    sd_access_num_d    = '0;
    sd_data_in_d       = '0;
    sd_write_request_d = 1'b0;
    sd_read_request_d  = 1'b0;

    if ((state_d == S_ISSUE) || (state_d == S_XFER)) begin
      sd_address_d    = addr_d;
      sd_access_num_d = 10'd1;
      sd_data_in_d    = wdata_d;
    end
    if (state_d == S_ISSUE) begin
      sd_write_request_d = write_d;
      sd_read_request_d  = ~write_d;
    end
    if (state_d == S_DONE) begin
      ack_d[port_d]   = 1'b1;
      error_d[port_d] = err_d;
      // Writes and aborted accesses return no data.
      rdata_d         = (err_d || write_d) ? 16'h0000 : rd_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= S_IDLE;
      port_q             <= 1'b0;
      write_q            <= 1'b0;
      addr_q             <= '0;
      wdata_q            <= '0;
      count_q            <= '0;
      err_q              <= 1'b0;
      rd_q               <= '0;
      last_q             <= 1'b1;
      rdata_q            <= '0;
      ack_q              <= '0;
      error_q            <= '0;
      busy_q             <= 1'b0;
      sd_address_q       <= '0;
      sd_access_num_q    <= '0;
      sd_data_in_q       <= '0;
      sd_write_request_q <= 1'b0;
      sd_read_request_q  <= 1'b0;
    end else begin
      state_q            <= state_d;
      port_q             <= port_d;
      write_q            <= write_d;
      addr_q             <= addr_d;
      wdata_q            <= wdata_d;
      count_q            <= count_d;
      err_q              <= err_d;
      rd_q               <= rd_d;
      last_q             <= last_d;
      rdata_q            <= rdata_d;
      ack_q              <= ack_d;
      error_q            <= error_d;
      busy_q             <= busy_d;
      sd_address_q       <= sd_address_d;
      sd_access_num_q    <= sd_access_num_d;
      sd_data_in_q       <= sd_data_in_d;
      sd_write_request_q <= sd_write_request_d;
      sd_read_request_q  <= sd_read_request_d;
    end
  end

  assign rdata            = rdata_q;
  assign ack              = ack_q;
  assign error            = error_q;
  assign busy             = busy_q;
  assign sd_address       = sd_address_q;
  assign sd_access_num    = sd_access_num_q;
  assign sd_data_in       = sd_data_in_q;
  assign sd_write_request = sd_write_request_q;
  assign sd_read_request  = sd_read_request_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Bench for sdram_access_arbiter: a behavioural SDRAM controller with its own
// memory answers the strobes, a round-robin reference model predicts ack order,
// error and read data, and a monitor pops the scoreboard on every ack.
module tb_sdram_access_arbiter;
  localparam int AW = 25;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    write = '0;
  logic [2*AW-1:0] address = '0;
  logic [31:0]   wdata = '0;
  logic [15:0]   rdata;
  logic [1:0]    ack;
  logic [1:0]    error;
  logic          busy;
  logic [AW-1:0] sd_address;
  logic [9:0]    sd_access_num;
  logic [15:0]   sd_data_in;
  logic [15:0]   sd_data_out = '0;
  logic          sd_write_request;
  logic          sd_read_request;
  logic          sd_write_flag = 1'b0;
  logic          sd_read_flag = 1'b0;
  logic          sd_idle = 1'b1;

  sdram_access_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .write(write), .address(address),
    .wdata(wdata), .rdata(rdata), .ack(ack), .error(error), .busy(busy),
    .sd_address(sd_address), .sd_access_num(sd_access_num), .sd_data_in(sd_data_in),
    .sd_data_out(sd_data_out), .sd_write_request(sd_write_request),
    .sd_read_request(sd_read_request), .sd_write_flag(sd_write_flag),
    .sd_read_flag(sd_read_flag), .sd_idle(sd_idle)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic w; logic [AW-1:0] a; logic [15:0] d; } txn_t;
  typedef struct packed { logic port; logic err; logic [15:0] rd; } exp_t;

  txn_t txq0[$];
  txn_t txq1[$];
  txn_t exp_acc[$];
  exp_t sb[$];
  logic [15:0] ref_mem [int];
  logic [15:0] env_mem [int];
  logic model_last = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int ctl_mode = 0;      // 0 normal, 1 never answer, 2 hold flag until released
  bit idle_block = 1'b0;
  int ack_window = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  task automatic add_txn(input int p, input logic w, input logic [AW-1:0] a, input logic [15:0] d);
    txn_t t;
    t.w = w; t.a = a; t.d = d;
    if (p == 0) txq0.push_back(t); else txq1.push_back(t);
  endtask

  task automatic add_rand(input int p);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 15));
    add_txn(p, 1'($urandom_range(0, 1)), a, 16'($urandom()));
  endtask

  task automatic present(input int p);
    txn_t t;
    if (p == 0) t = txq0.pop_front(); else t = txq1.pop_front();
    req[p] = 1'b1;
    write[p] = t.w;
    address[p*AW +: AW] = t.a;
    wdata[p*16 +: 16] = t.d;
  endtask

  // Predict grant order from the round-robin rule, push expectations, then drive.
  task automatic run_round(input bit stall, input int hold_idle, input bit drop_after_grant);
    int r0, r1, i0, i1, total, acks, cyc, g;
    txn_t t;
    exp_t e;
    r0 = txq0.size(); r1 = txq1.size(); i0 = 0; i1 = 0; total = r0 + r1;
    while (r0 + r1 > 0) begin
      if (r0 > 0 && r1 > 0) g = model_last ? 0 : 1;
      else g = (r0 > 0) ? 0 : 1;
      if (g == 0) begin t = txq0[i0]; i0++; r0--; end
      else begin t = txq1[i1]; i1++; r1--; end
      model_last = 1'(g);
      e.port = 1'(g);
      e.err = stall;
      e.rd = (stall || t.w) ? 16'h0000 : ref_read(t.a);
      sb.push_back(e);
      if (!stall) begin
        exp_acc.push_back(t);
        if (t.w) ref_mem[int'(t.a)] = t.d;
      end
    end
    ctl_mode = stall ? 1 : 0;
    if (hold_idle > 0) begin
      idle_block = 1'b1;
      repeat (2) @(negedge clock);
    end
    @(negedge clock);
    if (txq0.size() > 0) present(0);
    if (txq1.size() > 0) present(1);
    if (hold_idle > 0) begin
      repeat (hold_idle) begin
        @(negedge clock);
        chk("idle_hold_no_grant", {busy, sd_write_request, sd_read_request}, 0);
      end
      idle_block = 1'b0;
    end
    acks = 0; cyc = 0;
    while (acks < total && cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (drop_after_grant && busy && req != 2'b00) begin
        req = '0;
        address = (2*AW)'({$urandom(), $urandom()});
        wdata = $urandom();
        write = 2'($urandom());
      end
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          acks++;
          if ((p == 0 && txq0.size() > 0) || (p == 1 && txq1.size() > 0)) present(p);
          else req[p] = 1'b0;
        end
      end
    end
    chk("round_ack_count", acks, total);
    req = '0;
    ctl_mode = 0;
    repeat (2) @(negedge clock);
  endtask

  // Behavioural SDRAM controller.
  initial begin
    forever begin
      @(negedge clock);
      sd_idle = !idle_block;
      if (sd_write_request || sd_read_request) begin
        if (ctl_mode == 1) begin
          int n;
          n = 0;
          sd_idle = 1'b0;
          while ((sd_write_request || sd_read_request) && n < 100) begin
            n++;
            @(negedge clock);
          end
          chk("timeout_strobe_cycles", n, TO);
          repeat (3) @(negedge clock);
          sd_idle = 1'b1;
        end else begin
          logic w;
          logic [AW-1:0] a;
          logic [15:0] d;
          txn_t t;
          w = sd_write_request; a = sd_address; d = sd_data_in;
          chk("sd_access_num", sd_access_num, 1);
          if (exp_acc.size() == 0) begin
            chk("unexpected_access", 1, 0);
          end else begin
            t = exp_acc.pop_front();
            chk("access_dir", w, t.w);
            chk("access_addr", a, t.a);
            if (w) chk("access_wdata", d, t.d);
          end
          repeat ($urandom_range(0, 3)) @(negedge clock);
          sd_idle = 1'b0;
          if (w) begin
            sd_write_flag = 1'b1;
            env_mem[int'(a)] = d;
          end else begin
            sd_read_flag = 1'b1;
            sd_data_out = env_mem.exists(int'(a)) ? env_mem[int'(a)] : dflt(a);
          end
          if (ctl_mode == 2) begin
            while (ctl_mode == 2) @(negedge clock);
          end else begin
            repeat ($urandom_range(2, 4)) @(negedge clock);
          end
          sd_write_flag = 1'b0;
          sd_read_flag = 1'b0;
          sd_data_out = 16'($urandom());
          repeat ($urandom_range(0, 2)) @(negedge clock);
          sd_idle = 1'b1;
        end
      end
    end
  end

  // Monitor: one scoreboard entry per ack.
  always @(negedge clock) begin
    if (!reset) begin
      if (ack != 2'b00) begin
        ack_window++;
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", ack, e.port ? 2'b10 : 2'b01);
          chk("ack_error", error, e.err ? (e.port ? 2'b10 : 2'b01) : 2'b00);
          chk("ack_rdata", rdata, e.rd);
          $display("txn port=%0d err=%0d rdata=%h", e.port, e.err, rdata);
        end
      end else begin
        chk("error_without_ack", error, 0);
      end
      if (!busy) chk("idle_sd_outputs",
                     {sd_address, sd_access_num, sd_data_in, sd_write_request, sd_read_request}, 0);
    end
  end

  task automatic check_all_zero(input string name);
    chk(name, {ack, error, rdata, busy, sd_write_request, sd_read_request}, 0);
    chk(name, {sd_address, sd_access_num, sd_data_in}, 0);
  endtask

  initial begin
    int cyc;
    txn_t t;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Port 0 read returning 0xBEEF.
    ref_mem[32'h123] = 16'hBEEF;
    env_mem[32'h123] = 16'hBEEF;
    add_txn(0, 1'b0, 25'h0000123, 16'h1111);
    run_round(1'b0, 0, 1'b0);

    // Port 1 write to the top address, then read it back through port 0.
    add_txn(1, 1'b1, 25'h1FFFFFF, 16'h5A5A);
    run_round(1'b0, 0, 1'b0);
    add_txn(0, 1'b0, 25'h1FFFFFF, 16'h0000);
    run_round(1'b0, 0, 1'b0);

    // Controller never answers: timeout abort with error.
    add_txn(0, 1'b0, 25'h0000040, 16'h0000);
    run_round(1'b1, 0, 1'b0);

    // Controller not idle: request must wait.
    add_txn(0, 1'b0, 25'h0000007, 16'h0000);
    run_round(1'b0, 5, 1'b0);

    // Request withdrawn and fields scrambled after the grant.
    add_txn(0, 1'b1, 25'h0000009, 16'hC0DE);
    run_round(1'b0, 0, 1'b1);

    // Reset in the middle of a transfer: no ack, grant pointer back to port 1.
    t.w = 1'b0; t.a = 25'h0000055; t.d = 16'h0000;
    exp_acc.push_back(t);
    ctl_mode = 2;
    @(negedge clock);
    add_txn(0, t.w, t.a, t.d);
    present(0);
    cyc = 0;
    while (!(busy && sd_access_num == 10'd1 && !sd_read_request) && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    chk("reach_xfer", cyc < 50, 1);
    reset = 1'b1;
    req = '0;
    @(negedge clock);
    check_all_zero("reset_in_xfer");
    reset = 1'b0;
    ctl_mode = 0;
    model_last = 1'b1;
    ack_window = 0;
    repeat (8) @(negedge clock);
    chk("no_ack_after_reset", ack_window, 0);

    // Both ports continuously: alternating grants starting at port 0.
    add_txn(0, 1'b0, 25'h0000100, 16'h0);
    add_txn(0, 1'b0, 25'h0000101, 16'h0);
    add_txn(1, 1'b0, 25'h0000200, 16'h0);
    add_txn(1, 1'b0, 25'h0000201, 16'h0);
    run_round(1'b0, 0, 1'b0);

    // Randomised rounds.
    for (int r = 0; r < 30; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) add_rand(0);
      for (int i = 0; i < n1; i++) add_rand(1);
      run_round(1'b0, 0, 1'b0);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    chk("access_queue_empty", exp_acc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/sdram_access_arbiter.md
SDRAM_ACCESS_ARBITER -- requirements
Module: sdram_access_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 25: word address width of the SDRAM controller port.
REQ-002 Parameter TIMEOUT, default 1023: cycles allowed in ISSUE before abort; range 1..1023.
REQ-003 clock  in  1  single clock domain; the SDRAM controller runs on this same clock.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req  in  2  per-port access request; bit 0 = CPU port, bit 1 = DMA/video port; level, held until ack.
REQ-006 write  in  2  per-port direction: 1 = write, 0 = read; valid while req high.
REQ-007 address  in  2*ADDR_WIDTH  per-port word address; port n occupies bits [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 wdata  in  32  per-port write word; port n occupies bits [n*16 +: 16].
REQ-009 rdata  out  16  read word, shared by both ports; valid in the ack cycle only.
REQ-010 ack  out  2  one-cycle completion pulse to the granted port.
REQ-011 error  out  2  one-cycle pulse with ack when the access was aborted by timeout.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 sd_address  out  ADDR_WIDTH  address to the SDRAM controller.
REQ-014 sd_access_num  out  10  burst length; always 1 while granted, 0 in IDLE.
REQ-015 sd_data_in  out  16  write data to the SDRAM controller.
REQ-016 sd_data_out  in  16  read data from the SDRAM controller.
REQ-017 sd_write_request, sd_read_request  out  1 each  request strobes to the SDRAM controller.
REQ-018 sd_write_flag, sd_read_flag, sd_idle  in  1 each  controller status inputs.

Function
REQ-019 States SHALL be IDLE, ISSUE, XFER, DRAIN, DONE; the state and all registers SHALL be clocked on posedge clock.
REQ-020 IDLE: if any req bit is high and sd_idle=1, latch the winner's index, write, address and wdata, then go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: when both ports request, grant the port not granted last; when one port requests, grant it.
REQ-022 The last-grant register SHALL reset to 1, so port 0 wins the first simultaneous request.
REQ-023 ISSUE: drive the latched fields; hold sd_write_request or sd_read_request high per the latched direction.
REQ-024 ISSUE SHALL go to XFER in the cycle after the matching flag (write_flag or read_flag) is sampled high.
REQ-025 XFER: both request strobes low; while sd_read_flag is high, capture sd_data_out into the read register every cycle.
REQ-026 XFER SHALL go to DRAIN when the matching flag is sampled low.
REQ-027 DRAIN SHALL wait for sd_idle=1, then go to DONE.
REQ-028 DONE SHALL last exactly one cycle: pulse ack[granted]=1, drive rdata from the read register, update last-grant, then go to IDLE.
REQ-029 A req bit still high in the cycle after DONE SHALL be treated as a new request.
REQ-030 A 10-bit timeout counter SHALL clear on entry to ISSUE and increment each ISSUE cycle.
REQ-031 When the counter reaches TIMEOUT, drop the strobes, set the error latch and go to DRAIN; DONE then pulses error with ack, and rdata SHALL be 0.
REQ-032 rdata for a write access SHALL be 0.
REQ-033 Deassertion of the granted req before ack SHALL NOT abort the sequence; ack is still pulsed.
REQ-034 req, write, address and wdata changes after the latch cycle SHALL be ignored until the next IDLE.
REQ-035 The SDRAM outputs SHALL be 0 in IDLE, DRAIN and DONE; the latched values SHALL drive them only in ISSUE and XFER.

Reset
REQ-036 Reset asserted in any state SHALL return the block to IDLE immediately.
REQ-037 Reset SHALL clear ack, error, rdata, busy, all sd_* outputs, the latches, the timeout counter and the error latch to 0.
REQ-038 Reset SHALL set last-grant to 1.
REQ-039 An access interrupted by reset SHALL NOT produce ack.

Verification
REQ-040 Port 0 read of 0x00123, controller returns 0xBEEF -> single ack[0] with rdata=0xBEEF, error=0, sd_access_num=1 during the access.
REQ-041 Both ports request reads continuously for 4 accesses -> grant order 0,1,0,1 with exactly one ack per access.
REQ-042 Port 1 write of 0x5A5A to 0x1FFFFFF -> sd_address=0x1FFFFFF and sd_data_in=0x5A5A while sd_write_request is high; ack[1]=1 with rdata=0.
REQ-043 With TIMEOUT=8 and the flag held low -> strobe drops after 8 ISSUE cycles; after sd_idle, ack[0] and error[0] pulse together with rdata=0.
REQ-044 Reset asserted during XFER -> next cycle all outputs are 0 and state is IDLE; no ack; the next simultaneous request is granted to port 0.
REQ-045 sd_idle=0 while req[0]=1 in IDLE -> no grant and strobes stay 0 until sd_idle=1, then ISSUE starts.
